// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared definitions for the register-file writeback arbiter:
//     REG_AW / REG_DW  default register address / data widths
//     wb_src_e         requester index constants (ALU, FPU, LSU)
//     wrap_inc         round-robin pointer increment with wrap to zero
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    // Conventional requester slots on the writeback bus.
    typedef enum logic [2:0] {
        WB_ALU = 3'd0,
        WB_FPU = 3'd1,
        WB_LSU = 3'd2
    } wb_src_e;

    // Next round-robin start position after index cur won, out of n slots.
    function automatic int wrap_inc(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Writeback request bus between NREQ execute/memory sources and the arbiter.
//     req_valid[i]               source i has a write pending
//     req_fp[i]                  1 = fp_regfile, 0 = gp_regfile
//     req_addr[AW*i +: AW]       destination register of source i
//     req_data[DW*i +: DW]       write data of source i
//     req_ready[i]               accept strobe for source i
//
//   Handshake: a write transfers on a rising clk edge where req_valid[i] and
//   req_ready[i] are both 1. Once req_valid[i] rises, the source holds valid,
//   fp, addr and data stable until that transfer. req_ready is combinational
//   from the current request vector and arbiter pointers only; it never
//   depends on the source's own past ready values and there is no path from
//   valid back into valid.
//
//   modport master : the writeback sources
//   modport slave  : the arbiter
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_fp;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (
        output req_valid,
        output req_fp,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_fp,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_rr_arbiter
//   Purely combinational round-robin arbiter. The search starts at ptr and
//   wraps modulo N; the first asserted request wins.
//     req       in   N    request vector
//     ptr       in   PW   index where the search starts
//     gnt       out  N    one-hot grant (all zero when nothing requested)
//     any       out  1    a grant was issued
//     next_ptr  out  PW   winner+1 (wrapping) when any, else ptr unchanged
//   The pointer register itself lives in the instantiating module.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter_rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any,
    output logic [PW-1:0] next_ptr
);

    logic [PW-1:0] win;

    // Two passes give the wrap-around order without modulo arithmetic:
    // first the slots at or above ptr, then the slots below it.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        win = '0;
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (j >= int'(ptr))) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                win    = PW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (j < int'(ptr))) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                win    = PW'(j);
            end
        end
        next_ptr = any ? PW'(wrap_inc(int'(win), N)) : ptr;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single write port of gp_regfile and of fp_regfile among NREQ
//   writeback sources. Each file has its own round-robin pointer, so one gp
//   and one fp write can be accepted in the same cycle from different sources.
//   Write port outputs are registered one cycle after the grant.
//
//   Ports
//     clk, rst               rising-edge clock; synchronous active-high reset
//     wb (slave)             request bus, see regfile_wb_arbiter_if
//     gp_daddr/wdata/we      registered gp_regfile write port
//     fp_daddr/wdata/we      registered fp_regfile write port
//     dbg_ptr_gp/fp          current round-robin pointers (observation only)
//
//   gp r0 is hard-wired zero: a gp request to address 0 is accepted at once
//   without arbitrating, raising gp_we or moving the gp pointer. f0 is an
//   ordinary register.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_wb_arbiter_if.slave      wb,
    output logic [AW-1:0]            gp_daddr,
    output logic [DW-1:0]            gp_wdata,
    output logic                     gp_we,
    output logic [AW-1:0]            fp_daddr,
    output logic [DW-1:0]            fp_wdata,
    output logic                     fp_we,
    output logic [$clog2(NREQ)-1:0]  dbg_ptr_gp,
    output logic [$clog2(NREQ)-1:0]  dbg_ptr_fp
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr_gp;
    logic [PW-1:0]   ptr_fp;
    logic [PW-1:0]   nxt_gp;
    logic [PW-1:0]   nxt_fp;

    logic [NREQ-1:0] addr_nz;
    logic [NREQ-1:0] gp_cand;
    logic [NREQ-1:0] fp_cand;
    logic [NREQ-1:0] r0_drop;
    logic [NREQ-1:0] gp_gnt;
    logic [NREQ-1:0] fp_gnt;
    logic            gp_any;
    logic            fp_any;

    logic [AW-1:0]   gp_mux_addr;
    logic [DW-1:0]   gp_mux_data;
    logic [AW-1:0]   fp_mux_addr;
    logic [DW-1:0]   fp_mux_data;

    always_comb begin
        addr_nz = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_nz[i] = |wb.req_addr[AW*i +: AW];
        end
    end

    assign gp_cand = wb.req_valid & ~wb.req_fp & addr_nz;
    assign fp_cand = wb.req_valid &  wb.req_fp;
    assign r0_drop = wb.req_valid & ~wb.req_fp & ~addr_nz;

    regfile_wb_arbiter_rr_arbiter #(.N(NREQ), .PW(PW)) u_rr_gp (
        .req      (gp_cand),
        .ptr      (ptr_gp),
        .gnt      (gp_gnt),
        .any      (gp_any),
        .next_ptr (nxt_gp)
    );

    regfile_wb_arbiter_rr_arbiter #(.N(NREQ), .PW(PW)) u_rr_fp (
        .req      (fp_cand),
        .ptr      (fp_ptr_sel()),
        .gnt      (fp_gnt),
        .any      (fp_any),
        .next_ptr (nxt_fp)
    );

    function automatic logic [PW-1:0] fp_ptr_sel();
        return ptr_fp;
    endfunction

    // A source is never both a gp and an fp candidate, so the two grants and
    // the r0 drop are disjoint and can simply be ORed.
    assign wb.req_ready = rst ? '0 : (gp_gnt | fp_gnt | r0_drop);

    // One-hot AND-OR payload selection.
    always_comb begin
        gp_mux_addr = '0;
        gp_mux_data = '0;
        fp_mux_addr = '0;
        fp_mux_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            gp_mux_addr = gp_mux_addr | ({AW{gp_gnt[i]}} & wb.req_addr[AW*i +: AW]);
            gp_mux_data = gp_mux_data | ({DW{gp_gnt[i]}} & wb.req_data[DW*i +: DW]);
            fp_mux_addr = fp_mux_addr | ({AW{fp_gnt[i]}} & wb.req_addr[AW*i +: AW]);
            fp_mux_data = fp_mux_data | ({DW{fp_gnt[i]}} & wb.req_data[DW*i +: DW]);
        end
    end

    // Address and data hold when there is no grant; only we drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_gp   <= '0;
            ptr_fp   <= '0;
            gp_we    <= 1'b0;
            gp_daddr <= '0;
            gp_wdata <= '0;
            fp_we    <= 1'b0;
            fp_daddr <= '0;
            fp_wdata <= '0;
        end else begin
            gp_we <= gp_any;
            fp_we <= fp_any;
            if (gp_any) begin
                gp_daddr <= gp_mux_addr;
                gp_wdata <= gp_mux_data;
                ptr_gp   <= nxt_gp;
            end
            if (fp_any) begin
                fp_daddr <= fp_mux_addr;
                fp_wdata <= fp_mux_data;
                ptr_fp   <= nxt_fp;
            end
        end
    end

    assign dbg_ptr_gp = ptr_gp;
    assign dbg_ptr_fp = ptr_fp;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = REG_AW;
  localparam int DW   = REG_DW;
  localparam int PW   = $clog2(NREQ);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wb();

  logic [AW-1:0] gp_daddr, fp_daddr;
  logic [DW-1:0] gp_wdata, fp_wdata;
  logic          gp_we, fp_we;
  logic [PW-1:0] dbg_ptr_gp, dbg_ptr_fp;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb),
    .gp_daddr   (gp_daddr),
    .gp_wdata   (gp_wdata),
    .gp_we      (gp_we),
    .fp_daddr   (fp_daddr),
    .fp_wdata   (fp_wdata),
    .fp_we      (fp_we),
    .dbg_ptr_gp (dbg_ptr_gp),
    .dbg_ptr_fp (dbg_ptr_fp)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // Sources: one pending request each.
  logic          s_valid[NREQ];
  logic          s_fp[NREQ];
  logic [AW-1:0] s_addr[NREQ];
  logic [DW-1:0] s_data[NREQ];

  // Reference model state.
  int             m_ptr_gp, m_ptr_fp, m_gwin, m_fwin;
  logic [NREQ-1:0] m_ready, obs_ready;
  logic            m_gp_we, m_fp_we;
  logic [AW-1:0]   m_gp_daddr, m_fp_daddr;
  logic [DW-1:0]   m_gp_wdata, m_fp_wdata;
  logic [DW-1:0]   m_gpr[32], m_fpr[32];
  logic [DW-1:0]   t_gpr[32], t_fpr[32];

  // Scoreboard of expected writes, {addr, data}, in grant order.
  logic [AW+DW-1:0] gp_exp_q[$];
  logic [AW+DW-1:0] fp_exp_q[$];

  // Register files fed by the DUT write ports.
  always @(posedge clk) begin
    if (gp_we === 1'b1) t_gpr[gp_daddr] <= gp_wdata;
    if (fp_we === 1'b1) t_fpr[fp_daddr] <= fp_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic load(input int i, input logic f, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_valid[i] = 1'b1;
    s_fp[i]    = f;
    s_addr[i]  = a;
    s_data[i]  = d;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) begin
      s_valid[i] = 1'b0; s_fp[i] = 1'b0; s_addr[i] = '0; s_data[i] = '0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      wb.req_valid[i]           = s_valid[i];
      wb.req_fp[i]              = s_fp[i];
      wb.req_addr[AW*i +: AW]   = s_addr[i];
      wb.req_data[DW*i +: DW]   = s_data[i];
    end
  endtask

  // ---------------- reference model ----------------
  // Who should be accepted this cycle: per file, walk the sources starting at
  // the file's pointer and take the first eligible one.
  task automatic model_eval();
    int gi, fi;
    m_ready = '0;
    m_gwin  = -1;
    m_fwin  = -1;
    if (rst == 1'b0) begin
      for (int k = 0; k < NREQ; k++) begin
        gi = (m_ptr_gp + k) % NREQ;
        fi = (m_ptr_fp + k) % NREQ;
        if (m_gwin < 0 && s_valid[gi] && !s_fp[gi] && s_addr[gi] != '0) m_gwin = gi;
        if (m_fwin < 0 && s_valid[fi] && s_fp[fi]) m_fwin = fi;
      end
      for (int i = 0; i < NREQ; i++)
        if (s_valid[i] && !s_fp[i] && s_addr[i] == '0) m_ready[i] = 1'b1;
      if (m_gwin >= 0) m_ready[m_gwin] = 1'b1;
      if (m_fwin >= 0) m_ready[m_fwin] = 1'b1;
    end
  endtask

  // Effects of the clock edge on the expected write ports, pointers,
  // register contents and sources.
  task automatic model_update();
    if (rst) begin
      m_gp_we = 1'b0; m_gp_daddr = '0; m_gp_wdata = '0;
      m_fp_we = 1'b0; m_fp_daddr = '0; m_fp_wdata = '0;
      m_ptr_gp = 0; m_ptr_fp = 0;
    end else begin
      m_gp_we = (m_gwin >= 0);
      if (m_gwin >= 0) begin
        m_gp_daddr = s_addr[m_gwin];
        m_gp_wdata = s_data[m_gwin];
        m_ptr_gp   = (m_gwin + 1) % NREQ;
        m_gpr[s_addr[m_gwin]] = s_data[m_gwin];
        gp_exp_q.push_back({s_addr[m_gwin], s_data[m_gwin]});
      end
      m_fp_we = (m_fwin >= 0);
      if (m_fwin >= 0) begin
        m_fp_daddr = s_addr[m_fwin];
        m_fp_wdata = s_data[m_fwin];
        m_ptr_fp   = (m_fwin + 1) % NREQ;
        m_fpr[s_addr[m_fwin]] = s_data[m_fwin];
        fp_exp_q.push_back({s_addr[m_fwin], s_data[m_fwin]});
      end
      for (int i = 0; i < NREQ; i++)
        if (m_ready[i]) s_valid[i] = 1'b0;
    end
  endtask

  // One clock: drive, sample ready mid-cycle, step the edge, settle.
  task automatic cycle();
    drive();
    #1;
    model_eval();
    obs_ready = wb.req_ready;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    load(0, 1'b0, 5'd1, 32'd10);
    load(1, 1'b0, 5'd2, 32'd20);
    load(2, 1'b0, 5'd3, 32'd30);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (obs_ready !== '0) begin
        errors++; $display("FAIL reset_ready cycle %0d: got %b want 000", c, obs_ready);
      end
      checks++;
      if (gp_we !== 1'b0 || fp_we !== 1'b0) begin
        errors++; $display("FAIL reset_we cycle %0d: got gp=%b fp=%b want 0 0", c, gp_we, fp_we);
      end
      checks++;
      if (gp_daddr !== '0 || fp_daddr !== '0 || gp_wdata !== '0 || fp_wdata !== '0) begin
        errors++; $display("FAIL reset_payload cycle %0d: got gp %h/%h fp %h/%h want zeros",
                           c, gp_daddr, gp_wdata, fp_daddr, fp_wdata);
      end
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (obs_ready !== 3'b001) begin
      errors++; $display("FAIL first_grant_ready: got %b want 001", obs_ready);
    end
    checks++;
    if (gp_we !== 1'b1 || gp_daddr !== 5'd1 || gp_wdata !== 32'd10) begin
      errors++; $display("FAIL first_grant_write: got we=%b a=%0d d=%0d want 1 1 10", gp_we, gp_daddr, gp_wdata);
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (obs_ready !== m_ready || gp_we !== m_gp_we || gp_daddr !== m_gp_daddr) begin
        errors++; $display("FAIL reset_drain cycle %0d: got rdy=%b we=%b a=%0d want rdy=%b we=%b a=%0d",
                           c, obs_ready, gp_we, gp_daddr, m_ready, m_gp_we, m_gp_daddr);
      end
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_oh;
    load(0, 1'b0, 5'd1, 32'd10);
    load(1, 1'b0, 5'd2, 32'd20);
    load(2, 1'b0, 5'd3, 32'd30);
    for (int k = 0; k < 3; k++) begin
      cycle();
      exp_oh = NREQ'(1) << k;
      checks++;
      if (obs_ready !== exp_oh) begin
        errors++; $display("FAIL contention_ready %0d: got %b want %b", k, obs_ready, exp_oh);
      end
      checks++;
      if (gp_we !== 1'b1 || gp_daddr !== AW'(k + 1) || gp_wdata !== DW'(10 * (k + 1))) begin
        errors++; $display("FAIL contention_write %0d: got we=%b a=%0d d=%0d want 1 %0d %0d",
                           k, gp_we, gp_daddr, gp_wdata, k + 1, 10 * (k + 1));
      end
    end
    cycle();
    checks++;
    if (gp_we !== 1'b0 || gp_daddr !== 5'd3 || dbg_ptr_gp !== '0) begin
      errors++; $display("FAIL contention_idle: got we=%b a=%0d ptr=%0d want 0 3 0", gp_we, gp_daddr, dbg_ptr_gp);
    end
  endtask

  task automatic test_single_write();
    load(1, 1'b0, 5'd5, 32'h7);
    cycle();
    checks++;
    if (obs_ready !== 3'b010) begin
      errors++; $display("FAIL single_ready: got %b want 010", obs_ready);
    end
    checks++;
    if (gp_we !== 1'b1 || gp_daddr !== 5'd5 || gp_wdata !== 32'h7 || fp_we !== 1'b0) begin
      errors++; $display("FAIL single_write: got we=%b a=%0d d=%h fpwe=%b want 1 5 7 0", gp_we, gp_daddr, gp_wdata, fp_we);
    end
  endtask

  task automatic test_parallel_files();
    load(0, 1'b0, 5'd4, 32'd15);
    load(2, 1'b1, 5'd4, 32'd15);
    cycle();
    checks++;
    if (obs_ready !== 3'b101) begin
      errors++; $display("FAIL parallel_ready: got %b want 101", obs_ready);
    end
    checks++;
    if (gp_we !== 1'b1 || fp_we !== 1'b1 || gp_daddr !== 5'd4 || fp_daddr !== 5'd4 ||
        gp_wdata !== 32'd15 || fp_wdata !== 32'd15) begin
      errors++; $display("FAIL parallel_write: got gp %b/%0d/%0d fp %b/%0d/%0d want 1/4/15 both",
                         gp_we, gp_daddr, gp_wdata, fp_we, fp_daddr, fp_wdata);
    end
  endtask

  task automatic test_r0_drop();
    load(1, 1'b0, 5'd0, 32'd9);
    load(0, 1'b0, 5'd6, 32'd33);
    cycle();
    checks++;
    if (obs_ready !== 3'b011) begin
      errors++; $display("FAIL r0_ready: got %b want 011", obs_ready);
    end
    checks++;
    if (gp_we !== 1'b1 || gp_daddr !== 5'd6 || gp_wdata !== 32'd33) begin
      errors++; $display("FAIL r0_write: got we=%b a=%0d d=%0d want 1 6 33", gp_we, gp_daddr, gp_wdata);
    end
    cycle();
    checks++;
    if (gp_we !== 1'b0 || gp_daddr !== 5'd6 || dbg_ptr_gp !== PW'(m_ptr_gp)) begin
      errors++; $display("FAIL r0_after: got we=%b a=%0d ptr=%0d want 0 6 %0d", gp_we, gp_daddr, dbg_ptr_gp, m_ptr_gp);
    end
  endtask

  task automatic test_reset_mid();
    int writes;
    logic [AW+DW-1:0] e;
    writes = 0;
    gp_exp_q.delete();
    load(0, 1'b0, 5'd1, 32'd40);
    load(1, 1'b0, 5'd2, 32'd50);
    load(2, 1'b0, 5'd3, 32'd60);
    for (int c = 0; c < 8; c++) begin
      rst = (c == 1);
      cycle();
      checks++;
      if (obs_ready !== m_ready) begin
        errors++; $display("FAIL midrst_ready cycle %0d: got %b want %b", c, obs_ready, m_ready);
      end
      if (c == 1) begin
        checks++;
        if (gp_we !== 1'b0 || dbg_ptr_gp !== '0 || obs_ready !== '0) begin
          errors++; $display("FAIL midrst_clear: got we=%b ptr=%0d rdy=%b want 0 0 000", gp_we, dbg_ptr_gp, obs_ready);
        end
      end
      if (c == 2) begin
        checks++;
        if (obs_ready !== 3'b001) begin
          errors++; $display("FAIL midrst_restart: got %b want 001", obs_ready);
        end
      end
      if (gp_we === 1'b1) begin
        writes++;
        checks++;
        if (gp_exp_q.size() == 0) begin
          errors++; $display("FAIL midrst_extra_write: got a=%0d d=%0d want none", gp_daddr, gp_wdata);
        end else begin
          e = gp_exp_q.pop_front();
          if ({gp_daddr, gp_wdata} !== e) begin
            errors++; $display("FAIL midrst_write: got a=%0d d=%0d want a=%0d d=%0d",
                               gp_daddr, gp_wdata, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
    end
    rst = 1'b0;
    checks++;
    if (writes != 3 || gp_exp_q.size() != 0) begin
      errors++; $display("FAIL midrst_count: got %0d writes, %0d left want 3 writes, 0 left", writes, gp_exp_q.size());
    end
  endtask

  task automatic test_random();
    int waitc[NREQ];
    logic [AW+DW-1:0] e;
    gp_exp_q.delete();
    fp_exp_q.delete();
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!s_valid[i] && $urandom_range(0, 1) == 1) begin
          load(i, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31)), $urandom);
          waitc[i] = 0;
        end
      end
      cycle();
      checks++;
      if (obs_ready !== m_ready) begin
        errors++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, obs_ready, m_ready);
      end
      checks++;
      if ({gp_we, gp_daddr, gp_wdata} !== {m_gp_we, m_gp_daddr, m_gp_wdata}) begin
        errors++; $display("FAIL rand_gp cycle %0d: got %b/%0d/%h want %b/%0d/%h",
                           c, gp_we, gp_daddr, gp_wdata, m_gp_we, m_gp_daddr, m_gp_wdata);
      end
      checks++;
      if ({fp_we, fp_daddr, fp_wdata} !== {m_fp_we, m_fp_daddr, m_fp_wdata}) begin
        errors++; $display("FAIL rand_fp cycle %0d: got %b/%0d/%h want %b/%0d/%h",
                           c, fp_we, fp_daddr, fp_wdata, m_fp_we, m_fp_daddr, m_fp_wdata);
      end
      if (gp_we === 1'b1) begin
        checks++;
        e = (gp_exp_q.size() != 0) ? gp_exp_q.pop_front() : '1;
        if ({gp_daddr, gp_wdata} !== e) begin
          errors++; $display("FAIL rand_gp_order cycle %0d: got %0d/%h want %0d/%h", c, gp_daddr, gp_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
      if (fp_we === 1'b1) begin
        checks++;
        e = (fp_exp_q.size() != 0) ? fp_exp_q.pop_front() : '1;
        if ({fp_daddr, fp_wdata} !== e) begin
          errors++; $display("FAIL rand_fp_order cycle %0d: got %0d/%h want %0d/%h", c, fp_daddr, fp_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (wb.req_valid[i] === 1'b1) waitc[i]++;
        if (obs_ready[i] === 1'b1) begin
          checks++;
          if (waitc[i] > NREQ) begin
            errors++; $display("FAIL rand_starve src %0d: got wait %0d want <= %0d", i, waitc[i], NREQ);
          end
          waitc[i] = 0;
        end
      end
    end
  endtask

  task automatic test_regfile_contents();
    int bad_gp, bad_fp;
    clear_sources();
    cycle();
    cycle();
    bad_gp = 0;
    bad_fp = 0;
    for (int r = 0; r < 32; r++) begin
      if (t_gpr[r] !== m_gpr[r]) bad_gp++;
      if (t_fpr[r] !== m_fpr[r]) bad_fp++;
    end
    checks++;
    if (bad_gp != 0) begin
      errors++; $display("FAIL gpr_contents: got %0d differing registers want 0", bad_gp);
    end
    checks++;
    if (bad_fp != 0) begin
      errors++; $display("FAIL fpr_contents: got %0d differing registers want 0", bad_fp);
    end
    checks++;
    if (t_gpr[0] !== '0) begin
      errors++; $display("FAIL gpr_r0: got %h want 0", t_gpr[0]);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    clear_sources();
    for (int r = 0; r < 32; r++) begin
      m_gpr[r] = '0; m_fpr[r] = '0; t_gpr[r] = '0; t_fpr[r] = '0;
    end
    m_ptr_gp = 0; m_ptr_fp = 0;
    m_gp_we = 1'b0; m_fp_we = 1'b0;
    m_gp_daddr = '0; m_fp_daddr = '0; m_gp_wdata = '0; m_fp_wdata = '0;
    drive();

    test_reset();
    test_contention();
    test_single_write();
    test_parallel_files();
    test_r0_drop();
    test_reset_mid();
    test_random();
    test_regfile_contents();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
